// File: rtl/id_ex_stage.sv
// id_ex_stage: decode->execute pipeline register feeding the ALU.
// Holds one decoded instruction and selects each operand source (regfile, PC or immediate).
// Results from the MEM and WB producers are forwarded, with MEM taking priority.
// A load-use hazard against the MEM producer stalls the stage.
// The held regfile data is refreshed from WB while the instruction waits.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   in_valid / in_ready        decode-side handshake
//   in_rs1, in_rs2             source register addresses
//   in_rs1_data, in_rs2_data   regfile read data
//   in_pc, in_imm              instruction PC and sign-extended immediate
//   in_a_pc, in_b_imm          operand select (a = PC, b = imm)
//   in_alu_mode                ALU opcode
//   in_rd, in_rd_we            destination register and its write enable
//   in_is_load, in_is_store    memory operation class
//   flush                      kills both the held and the incoming instruction
//   mem_rd/mem_we/mem_data     MEM-stage producer; mem_is_load means its data is not ready yet
//   wb_rd/wb_we/wb_data        WB-stage producer
//   ex_ready / ex_valid        EX-side handshake
//   alu_a, alu_b, alu_mode     ALU operands and opcode
//   ex_store_data              forwarded rs2, used by stores
//   ex_rd, ex_rd_we            held destination fields
//   ex_is_load, ex_is_store    held memory-class fields
//   hazard                     load-use stall is active
module id_ex_stage #(
  parameter int WordSize = 32,
  parameter int RegBits  = 5
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RegBits-1:0]  in_rs1,
  input  logic [RegBits-1:0]  in_rs2,
  input  logic [WordSize-1:0] in_rs1_data,
  input  logic [WordSize-1:0] in_rs2_data,
  input  logic [WordSize-1:0] in_pc,
  input  logic [WordSize-1:0] in_imm,
  input  logic                in_a_pc,
  input  logic                in_b_imm,
  input  logic [4:0]          in_alu_mode,
  input  logic [RegBits-1:0]  in_rd,
  input  logic                in_rd_we,
  input  logic                in_is_load,
  input  logic                in_is_store,
  input  logic                flush,
  input  logic [RegBits-1:0]  mem_rd,
  input  logic                mem_we,
  input  logic [WordSize-1:0] mem_data,
  input  logic                mem_is_load,
  input  logic [RegBits-1:0]  wb_rd,
  input  logic                wb_we,
  input  logic [WordSize-1:0] wb_data,
  input  logic                ex_ready,
  output logic                ex_valid,
  output logic [WordSize-1:0] alu_a,
  output logic [WordSize-1:0] alu_b,
  output logic [4:0]          alu_mode,
  output logic [WordSize-1:0] ex_store_data,
  output logic [RegBits-1:0]  ex_rd,
  output logic                ex_rd_we,
  output logic                ex_is_load,
  output logic                ex_is_store,
  output logic                hazard
);

  typedef enum logic [1:0] {EMPTY, HELD, STALL} state_t;

  // Only EMPTY/HELD are stored; STALL is HELD qualified by the live hazard,
  // because the hazard depends on what the MEM stage presents this cycle.
  state_t state_q;
  state_t state;

  logic [RegBits-1:0]  rs1_q, rs2_q, rd_q;
  logic [WordSize-1:0] rs1_data_q, rs2_data_q, pc_q, imm_q;
  logic [4:0]          mode_q;
  logic                a_pc_q, b_imm_q, rd_we_q, is_load_q, is_store_q;

  logic [WordSize-1:0] fwd1, fwd2;
  logic                valid, hazard_c, advance, capture;

  always_comb begin
    fwd1 = rs1_data_q;
    if (rs1_q == '0)                         fwd1 = '0;
    else if (mem_we && (mem_rd == rs1_q))    fwd1 = mem_data;
    else if (wb_we && (wb_rd == rs1_q))      fwd1 = wb_data;

    fwd2 = rs2_data_q;
    if (rs2_q == '0)                         fwd2 = '0;
    else if (mem_we && (mem_rd == rs2_q))    fwd2 = mem_data;
    else if (wb_we && (wb_rd == rs2_q))      fwd2 = wb_data;
  end

  always_comb begin
    valid    = (state_q != EMPTY);
    // rs2 counts as a used source for stores even when b takes the immediate.
    hazard_c = valid && mem_is_load && mem_we && (mem_rd != '0) &&
               ((!a_pc_q && (mem_rd == rs1_q)) ||
                ((!b_imm_q || is_store_q) && (mem_rd == rs2_q)));
    state    = !valid ? EMPTY : (hazard_c ? STALL : HELD);
    ex_valid = (state == HELD) && !flush;
    advance  = ex_valid && ex_ready;
    in_ready = !valid || advance;
    capture  = in_valid && in_ready && !flush;
  end

  always_comb begin
    hazard        = hazard_c;
    alu_a         = a_pc_q ? pc_q : fwd1;
    alu_b         = b_imm_q ? imm_q : fwd2;
    alu_mode      = mode_q;
    ex_store_data = fwd2;
    ex_rd         = rd_q;
    ex_rd_we      = rd_we_q;
    ex_is_load    = is_load_q;
    ex_is_store   = is_store_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= EMPTY;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      mode_q     <= '0;
      a_pc_q     <= 1'b0;
      b_imm_q    <= 1'b0;
      rd_we_q    <= 1'b0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else if (capture) begin
      state_q    <= HELD;
      rs1_q      <= in_rs1;
      rs2_q      <= in_rs2;
      rd_q       <= in_rd;
      rs1_data_q <= in_rs1_data;
      rs2_data_q <= in_rs2_data;
      pc_q       <= in_pc;
      imm_q      <= in_imm;
      mode_q     <= in_alu_mode;
      a_pc_q     <= in_a_pc;
      b_imm_q    <= in_b_imm;
      rd_we_q    <= in_rd_we;
      is_load_q  <= in_is_load;
      is_store_q <= in_is_store;
    end else if (advance) begin
      state_q <= EMPTY;
    end else if (valid) begin
      // A WB producer retiring while we wait must not be lost once it leaves WB.
      if (wb_we && (wb_rd == rs1_q) && (rs1_q != '0)) rs1_data_q <= wb_data;
      if (wb_we && (wb_rd == rs2_q) && (rs2_q != '0)) rs2_data_q <= wb_data;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized plus directed stimulus for id_ex_stage.
// A stimulus process drives one cycle at a time and pushes the behavioural model's
// prediction into scoreboard queues. A monitor process checks the DUT against those queues.
module tb_id_ex_stage;

  typedef struct {
    logic        in_valid;
    logic [4:0]  rs1, rs2, rd, mode;
    logic [31:0] rs1_data, rs2_data, pc, imm;
    logic        a_pc, b_imm, rd_we, is_load, is_store, flush;
    logic [4:0]  mem_rd;
    logic        mem_we, mem_is_load;
    logic [31:0] mem_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
    logic        ex_ready;
  } stim_t;

  typedef struct {
    logic        ex_valid, hazard, in_ready, cmp_fields;
    logic [31:0] alu_a, alu_b, store_data;
    logic [4:0]  mode, rd;
    logic        rd_we, is_load, is_store;
  } exp_t;

  logic        clk, rstn;
  logic        in_valid, in_ready, in_a_pc, in_b_imm, in_rd_we, in_is_load, in_is_store, flush;
  logic [4:0]  in_rs1, in_rs2, in_rd, in_alu_mode, mem_rd, wb_rd, alu_mode, ex_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_pc, in_imm, mem_data, wb_data;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic        mem_we, mem_is_load, wb_we, ex_ready, ex_valid;
  logic        ex_rd_we, ex_is_load, ex_is_store, hazard;

  id_ex_stage #(.WordSize(32), .RegBits(5)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_a_pc(in_a_pc), .in_b_imm(in_b_imm), .in_alu_mode(in_alu_mode),
    .in_rd(in_rd), .in_rd_we(in_rd_we),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .flush(flush),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_data(mem_data), .mem_is_load(mem_is_load),
    .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
    .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .hazard(hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t ctrl_q[$];
  exp_t tx_q[$];

  // Reference model: the resident instruction as a record.
  logic  m_valid;
  logic  m_fresh;  // fields still hold their reset zeros
  stim_t m_ins;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.ex_ready = 1'b1;
    return s;
  endfunction

  function automatic stim_t ins(input logic [4:0] r1, input logic [4:0] r2,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic a_pc, input logic b_imm);
    stim_t s;
    s = idle();
    s.in_valid = 1'b1;
    s.rs1 = r1; s.rs2 = r2; s.rs1_data = d1; s.rs2_data = d2;
    s.a_pc = a_pc; s.b_imm = b_imm;
    s.pc = 32'h0000_1000; s.imm = 32'hFFFF_FFF0;
    s.rd = 5'd3; s.rd_we = 1'b1; s.mode = 5'h00;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.in_valid    = ($urandom_range(0, 9) < 7);
    s.rs1         = 5'($urandom_range(0, 3));
    s.rs2         = 5'($urandom_range(0, 3));
    s.rd          = 5'($urandom_range(0, 31));
    s.mode        = 5'($urandom_range(0, 31));
    s.rs1_data    = $urandom;
    s.rs2_data    = $urandom;
    s.pc          = $urandom;
    s.imm         = $urandom;
    s.a_pc        = ($urandom_range(0, 4) == 0);
    s.b_imm       = ($urandom_range(0, 9) < 3);
    s.rd_we       = 1'($urandom_range(0, 1));
    s.is_load     = ($urandom_range(0, 3) == 0);
    s.is_store    = ($urandom_range(0, 3) == 0);
    s.flush       = ($urandom_range(0, 11) == 0);
    s.mem_rd      = 5'($urandom_range(0, 3));
    s.mem_we      = 1'($urandom_range(0, 1));
    s.mem_is_load = ($urandom_range(0, 9) < 3);
    s.mem_data    = $urandom;
    s.wb_rd       = 5'($urandom_range(0, 3));
    s.wb_we       = 1'($urandom_range(0, 1));
    s.wb_data     = $urandom;
    s.ex_ready    = ($urandom_range(0, 9) < 7);
    return s;
  endfunction

  // Newest value of register r: x0 is zero, then the youngest producer, then the held read.
  function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] held,
                                         input stim_t s);
    logic [4:0]  prd  [2];
    logic        pwe  [2];
    logic [31:0] pdat [2];
    logic [31:0] v;
    logic        found;
    prd[0] = s.mem_rd; pwe[0] = s.mem_we; pdat[0] = s.mem_data;
    prd[1] = s.wb_rd;  pwe[1] = s.wb_we;  pdat[1] = s.wb_data;
    v = held;
    found = 1'b0;
    for (int i = 0; i < 2; i++)
      if (!found && pwe[i] && prd[i] == r) begin
        v = pdat[i];
        found = 1'b1;
      end
    return (r == 5'd0) ? 32'd0 : v;
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    logic uses1, uses2, waits_on_load;
    uses1 = !m_ins.a_pc;
    uses2 = !m_ins.b_imm || m_ins.is_store;
    waits_on_load = s.mem_is_load && s.mem_we && s.mem_rd != 5'd0 &&
                    ((uses1 && s.mem_rd == m_ins.rs1) || (uses2 && s.mem_rd == m_ins.rs2));
    e.hazard     = m_valid && waits_on_load;
    e.ex_valid   = m_valid && !e.hazard && !s.flush;
    e.in_ready   = !m_valid || (e.ex_valid && s.ex_ready);
    e.cmp_fields = m_valid || m_fresh;
    e.alu_a      = m_ins.a_pc  ? m_ins.pc  : newest(m_ins.rs1, m_ins.rs1_data, s);
    e.alu_b      = m_ins.b_imm ? m_ins.imm : newest(m_ins.rs2, m_ins.rs2_data, s);
    e.store_data = newest(m_ins.rs2, m_ins.rs2_data, s);
    e.mode       = m_ins.mode;
    e.rd         = m_ins.rd;
    e.rd_we      = m_ins.rd_we;
    e.is_load    = m_ins.is_load;
    e.is_store   = m_ins.is_store;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    in_valid = s.in_valid; in_rs1 = s.rs1; in_rs2 = s.rs2;
    in_rs1_data = s.rs1_data; in_rs2_data = s.rs2_data;
    in_pc = s.pc; in_imm = s.imm; in_a_pc = s.a_pc; in_b_imm = s.b_imm;
    in_alu_mode = s.mode; in_rd = s.rd; in_rd_we = s.rd_we;
    in_is_load = s.is_load; in_is_store = s.is_store; flush = s.flush;
    mem_rd = s.mem_rd; mem_we = s.mem_we; mem_data = s.mem_data; mem_is_load = s.mem_is_load;
    wb_rd = s.wb_rd; wb_we = s.wb_we; wb_data = s.wb_data; ex_ready = s.ex_ready;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_fresh = 1'b1;
    m_ins   = '{default: '0};
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    logic leave, take;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(s);
    e = predict(s);
    ctrl_q.push_back(e);
    leave = e.ex_valid && s.ex_ready;
    take  = s.in_valid && e.in_ready && !s.flush;
    if (leave) tx_q.push_back(e);
    if (s.flush) begin
      m_valid = 1'b0; m_fresh = 1'b0;
    end else if (take) begin
      m_ins = s; m_valid = 1'b1; m_fresh = 1'b0;
    end else if (leave) begin
      m_valid = 1'b0;
    end else if (m_valid) begin
      if (s.wb_we && s.wb_rd == m_ins.rs1 && m_ins.rs1 != 5'd0) m_ins.rs1_data = s.wb_data;
      if (s.wb_we && s.wb_rd == m_ins.rs2 && m_ins.rs2 != 5'd0) m_ins.rs2_data = s.wb_data;
    end
  endtask

  // Reset asserted mid-cycle; held for one clock edge.
  task automatic reset_cycle();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    drive(idle());
    model_reset();
    ctrl_q.push_back(predict(idle()));
  endtask

  // Monitor: per-cycle control/operand check, plus a transfer check on every EX handshake.
  initial begin
    exp_t e, t;
    forever begin
      @(negedge clk);
      if (ctrl_q.size() > 0) begin
        e = ctrl_q.pop_front();
        chk("ex_valid", 32'(ex_valid), 32'(e.ex_valid));
        chk("hazard",   32'(hazard),   32'(e.hazard));
        chk("in_ready", 32'(in_ready), 32'(e.in_ready));
        if (e.cmp_fields) begin
          chk("alu_a",      alu_a,            e.alu_a);
          chk("alu_b",      alu_b,            e.alu_b);
          chk("alu_mode",   32'(alu_mode),    32'(e.mode));
          chk("store_data", ex_store_data,    e.store_data);
          chk("ex_rd",      32'(ex_rd),       32'(e.rd));
        end
      end
      if (ex_valid && ex_ready) begin
        if (tx_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL tx_unexpected: DUT advanced with alu_a=%h, model expected none", alu_a);
        end else begin
          t = tx_q.pop_front();
          chk("tx_alu_a",    alu_a,              t.alu_a);
          chk("tx_alu_b",    alu_b,              t.alu_b);
          chk("tx_store",    ex_store_data,      t.store_data);
          chk("tx_mode",     32'(alu_mode),      32'(t.mode));
          chk("tx_rd",       32'(ex_rd),         32'(t.rd));
          chk("tx_rd_we",    32'(ex_rd_we),      32'(t.rd_we));
          chk("tx_is_load",  32'(ex_is_load),    32'(t.is_load));
          chk("tx_is_store", 32'(ex_is_store),   32'(t.is_store));
        end
      end
    end
  end

  initial begin
    stim_t s;
    rstn = 1'b0;
    drive(idle());
    model_reset();
    repeat (2) @(posedge clk);

    // 1: reset while an instruction is held
    step(idle());
    s = ins(5'd1, 5'd2, 32'd11, 32'd22, 1'b0, 1'b0); s.ex_ready = 1'b0; s.mode = 5'h10;
    step(s);
    s = idle(); s.ex_ready = 1'b0;
    step(s);
    reset_cycle();
    step(idle());

    // 2: MEM beats WB on rs1
    s = ins(5'd1, 5'd2, 32'd5, 32'd7, 1'b0, 1'b0); s.ex_ready = 1'b0;
    step(s);
    s = idle(); s.ex_ready = 1'b0;
    s.mem_we = 1'b1; s.mem_rd = 5'd1; s.mem_data = 32'd20;
    s.wb_we  = 1'b1; s.wb_rd  = 5'd1; s.wb_data  = 32'd9;
    step(s);
    s.ex_ready = 1'b1;
    step(s);

    // 3: load-use stall, resolved by WB next cycle
    s = ins(5'd4, 5'd0, 32'd1, 32'd0, 1'b0, 1'b1);
    step(s);
    s = ins(5'd2, 5'd2, 32'd3, 32'd3, 1'b0, 1'b0);
    s.mem_we = 1'b1; s.mem_rd = 5'd4; s.mem_is_load = 1'b1; s.mem_data = 32'hDEAD;
    step(s);
    s = idle(); s.wb_we = 1'b1; s.wb_rd = 5'd4; s.wb_data = 32'hAB;
    step(s);

    // 4: x0 source ignores a MEM producer targeting x0
    s = ins(5'd0, 5'd1, 32'h1234, 32'd8, 1'b0, 1'b1); s.ex_ready = 1'b0;
    step(s);
    s = idle(); s.mem_we = 1'b1; s.mem_rd = 5'd0; s.mem_data = 32'hFF; s.mem_is_load = 1'b1;
    step(s);

    // 5: EX backpressure, WB retires rs2 during the wait
    s = idle(); s.flush = 1'b1;
    step(s);
    s = ins(5'd1, 5'd6, 32'd1, 32'd2, 1'b0, 1'b0); s.ex_ready = 1'b0;
    step(s);
    s = idle(); s.ex_ready = 1'b0; s.wb_we = 1'b1; s.wb_rd = 5'd6; s.wb_data = 32'h55;
    step(s);
    s = idle(); s.ex_ready = 1'b0;
    step(s);
    step(s);
    step(idle());

    // 6: flush beats capture and ex_ready
    s = ins(5'd1, 5'd2, 32'd1, 32'd2, 1'b0, 1'b0); s.ex_ready = 1'b0;
    step(s);
    s = ins(5'd3, 5'd3, 32'd9, 32'd9, 1'b1, 1'b1); s.flush = 1'b1;
    step(s);
    step(idle());

    // randomized traffic with occasional resets
    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) reset_cycle();
      else step(rand_stim());
    end

    repeat (3) step(idle());
    @(negedge clk);
    @(negedge clk);
    chk("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
